trws_scan_sequencer: RTL and testbench
======================================

Name: trws_scan_sequencer

Overview:
- Per-pixel scheduler that feeds the sequential TRW-S message passer and consumes its results.
- Scans a rectangular image grid in forward order (raster from (0,0)) or reverse order (from (IMG_WIDTH-1, IMG_HEIGHT-1)).
- For each pixel it fetches data costs and backward messages from the message store, builds forward messages, issues one push, waits for valid, then writes the outputs back.
- Holds the previous pixel's horizontal output in a register and the previous row's vertical outputs in an IMG_WIDTH-entry line buffer.

Parameters:
- LABELS, 16, labels per pixel
- MESSAGE_WIDTH, 6, bits per label message
- DATA_WIDTH, 8, bits per label data cost
- IMG_WIDTH, 64, pixels per row
- IMG_HEIGHT, 48, rows per image
- COL_BITS, 6, width of column index
- ROW_BITS, 6, width of row index

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  begin a scan; accepted only in IDLE
- reverse  in  1  scan direction; sampled when start is accepted
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the last pixel is written back
- err  out  1  sticky: valid seen outside WAIT; cleared on accepted start
- pix_req  out  1  fetch request for pixel (pix_x, pix_y)
- pix_x  out  COL_BITS  column being fetched
- pix_y  out  ROW_BITS  row being fetched
- pix_ack  in  1  fetch data valid this cycle
- pix_data  in  LABELS*DATA_WIDTH  data costs
- pix_h_bwd  in  LABELS*MESSAGE_WIDTH  horizontal backward message
- pix_v_bwd  in  LABELS*MESSAGE_WIDTH  vertical backward message
- push  out  1  issue to passer
- horizontal_message_forward  out  LABELS*MESSAGE_WIDTH  to passer
- horizontal_message_backward  out  LABELS*MESSAGE_WIDTH  to passer
- vertical_message_forward  out  LABELS*MESSAGE_WIDTH  to passer
- vertical_message_backward  out  LABELS*MESSAGE_WIDTH  to passer
- data  out  LABELS*DATA_WIDTH  to passer
- valid  in  1  result valid from passer
- horizontal_out  in  LABELS*MESSAGE_WIDTH  from passer
- vertical_out  in  LABELS*MESSAGE_WIDTH  from passer
- wb_valid  out  1  one-cycle writeback strobe
- wb_x  out  COL_BITS  writeback column
- wb_y  out  ROW_BITS  writeback row
- wb_h_msg  out  LABELS*MESSAGE_WIDTH  registered horizontal_out
- wb_v_msg  out  LABELS*MESSAGE_WIDTH  registered vertical_out

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0; x, y and h_prev register 0.
  - Line buffer contents are not reset; they are never read before being written in a scan.
- States:
  - IDLE: on start, go to REQ. Latch reverse. Set x,y to (0,0) forward or (IMG_WIDTH-1, IMG_HEIGHT-1) reverse. Clear err.
  - REQ: pix_req=1 with pix_x=x, pix_y=y. On pix_ack, register pix_data, pix_h_bwd and pix_v_bwd onto the passer ports, and go to ISSUE.
    - Forward h message = h_prev, or 0 if x is the first column of the scan (0 forward, IMG_WIDTH-1 reverse).
    - Forward v message = linebuf[x], or 0 if y is the first row of the scan.
  - ISSUE: push=1 for exactly one cycle; go to WAIT. Passer inputs stay stable from ISSUE until the next REQ acceptance.
  - WAIT: on valid, register horizontal_out and vertical_out into wb_h_msg and wb_v_msg, set wb_x=x and wb_y=y, and go to WB. There is no timeout.
  - WB:
    - wb_valid=1; h_prev<=wb_h_msg; linebuf[x]<=wb_v_msg.
    - If (x,y) is the last pixel of the scan, go to DONE.
    - Otherwise advance x by ±1. At row end, wrap x to the first column and step y by ±1. Go to REQ.
  - DONE: done=1 for one cycle; go to IDLE.
- Timing: the passer's latency is 8 cycles, so valid arrives in cycle N+8 for an ISSUE in cycle N. With pix_ack tied high, the pixel period is exactly 11 cycles (REQ 1, ISSUE 1, WAIT 8, WB 1).
- Ignored inputs:
  - start while busy is ignored.
  - pix_ack outside REQ is ignored.
- valid outside WAIT sets err. Its data is discarded and the state is unchanged.
- Asserting rst mid-scan returns to IDLE on the next edge with all outputs 0. No partial done or wb_valid is produced.
- Width rules:
  - All messages are carried bit-exact; no arithmetic is performed on message payloads.
  - Coordinate wrap uses explicit compares against IMG_WIDTH-1 and IMG_HEIGHT-1, not modulo overflow.

Decomposition:
- Shared package trws_pkg holds:
  - LABELS, MESSAGE_WIDTH, DATA_WIDTH and the derived bus widths.
  - The state encoding typedef, shared with a future message-store controller.
- One sub-module: trws_line_buffer, a single-port synchronous-write, asynchronous-read array of IMG_WIDTH entries, each LABELS*MESSAGE_WIDTH wide.

Test Plan:
- Forward 2x2 image, pix_ack tied high, passer modelled as an 8-cycle delay returning horizontal_out=vertical_out=pixel index in all labels:
  - wb order is (0,0), (1,0), (0,1), (1,1).
  - done asserts 44 cycles after the start edge.
  - Pixel (1,1) push carries h fwd=2 and v fwd=1 in every label.
- Boundary zeros: with the same model, pixel (0,0) push has h and v fwd=0; pixel (0,1) has h fwd=0 and v fwd from (0,0).
- Reverse 2x2: wb order is (1,1), (0,1), (1,0), (0,0); pixel (1,0) has h fwd=0 and v fwd = output of (1,1).
- pix_ack delayed 5 cycles on every pixel: pixel period is 16 cycles and push stays one cycle wide; start pulsed mid-scan is ignored.
- Spurious valid injected during REQ: err=1, no wb_valid, the scan completes normally; the next start clears err.
- rst asserted during WAIT of pixel (1,0): outputs 0 immediately, busy=0, then a fresh start rescans from (0,0).

Source files
------------

// File: rtl/trws_pkg.sv
// Shared TRW-S types: message/data bus widths and the scan state encoding.
// The message-store controller uses the same state encoding.
package trws_pkg;

    localparam int LABELS        = 16;
    localparam int MESSAGE_WIDTH = 6;
    localparam int DATA_WIDTH    = 8;
    localparam int MSG_BUS_W     = LABELS * MESSAGE_WIDTH;
    localparam int DATA_BUS_W    = LABELS * DATA_WIDTH;

    typedef logic [MSG_BUS_W-1:0]  msg_bus_t;
    typedef logic [DATA_BUS_W-1:0] data_bus_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_WB    = 3'd4,
        ST_DONE  = 3'd5
    } scan_state_t;

endpackage

// File: rtl/trws_scan_sequencer_if.sv
// Control, pixel fetch, passer and writeback signals of the scan sequencer.
// The master modport is the sequencer side; the slave modport is the store/passer side.
interface trws_scan_sequencer_if
    import trws_pkg::*;
#(
    parameter int COL_BITS = 6,
    parameter int ROW_BITS = 6
) ();

    logic                start;
    logic                reverse;
    logic                busy;
    logic                done;
    logic                err;

    logic                pix_req;
    logic [COL_BITS-1:0] pix_x;
    logic [ROW_BITS-1:0] pix_y;
    logic                pix_ack;
    data_bus_t           pix_data;
    msg_bus_t            pix_h_bwd;
    msg_bus_t            pix_v_bwd;

    logic                push;
    msg_bus_t            horizontal_message_forward;
    msg_bus_t            horizontal_message_backward;
    msg_bus_t            vertical_message_forward;
    msg_bus_t            vertical_message_backward;
    data_bus_t           data;
    logic                valid;
    msg_bus_t            horizontal_out;
    msg_bus_t            vertical_out;

    logic                wb_valid;
    logic [COL_BITS-1:0] wb_x;
    logic [ROW_BITS-1:0] wb_y;
    msg_bus_t            wb_h_msg;
    msg_bus_t            wb_v_msg;

    modport master (
        input  start, reverse, pix_ack, pix_data, pix_h_bwd, pix_v_bwd,
               valid, horizontal_out, vertical_out,
        output busy, done, err, pix_req, pix_x, pix_y, push,
               horizontal_message_forward, horizontal_message_backward,
               vertical_message_forward, vertical_message_backward, data,
               wb_valid, wb_x, wb_y, wb_h_msg, wb_v_msg
    );

    modport slave (
        output start, reverse, pix_ack, pix_data, pix_h_bwd, pix_v_bwd,
               valid, horizontal_out, vertical_out,
        input  busy, done, err, pix_req, pix_x, pix_y, push,
               horizontal_message_forward, horizontal_message_backward,
               vertical_message_forward, vertical_message_backward, data,
               wb_valid, wb_x, wb_y, wb_h_msg, wb_v_msg
    );

endinterface

// File: rtl/trws_line_buffer.sv
// Previous-row vertical messages, one entry per column.
// Synchronous write, asynchronous read.
module trws_line_buffer
    import trws_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter int ADDR_BITS = 6
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  msg_bus_t             wdata,
    output msg_bus_t             rdata
);

    msg_bus_t mem [DEPTH];

    // NOTE: no reset on the array; every entry is written in row 0 of a scan before any read uses it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/trws_scan_sequencer.sv
// Per-pixel TRW-S scheduler: fetch, build forward messages, push, await valid, write back.
// Scans raster order forward from (0,0) or reverse from the last pixel.
module trws_scan_sequencer
    import trws_pkg::*;
#(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 48,
    parameter int COL_BITS   = 6,
    parameter int ROW_BITS   = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    trws_scan_sequencer_if.master bus
);

    localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(IMG_WIDTH - 1);
    localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(IMG_HEIGHT - 1);

    scan_state_t         state, state_nxt;
    logic [COL_BITS-1:0] x;
    logic [ROW_BITS-1:0] y;
    logic                rev;
    logic                err_q;
    msg_bus_t            h_prev;
    msg_bus_t            lb_rdata;
    msg_bus_t            h_fwd_q, h_bwd_q, v_fwd_q, v_bwd_q;
    data_bus_t           data_q;
    msg_bus_t            wb_h_q, wb_v_q;
    logic [COL_BITS-1:0] wb_x_q;
    logic [ROW_BITS-1:0] wb_y_q;
    logic                first_col, first_row, last_col, last_row;

    // "First" and "last" swap with scan direction.
    assign first_col = rev ? (x == LAST_COL) : (x == '0);
    assign first_row = rev ? (y == LAST_ROW) : (y == '0);
    assign last_col  = rev ? (x == '0) : (x == LAST_COL);
    assign last_row  = rev ? (y == '0) : (y == LAST_ROW);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt    = state;
        bus.busy     = (state != ST_IDLE);
        bus.pix_req  = 1'b0;
        bus.push     = 1'b0;
        bus.wb_valid = 1'b0;
        bus.done     = 1'b0;
        case (state)
            ST_IDLE:  if (bus.start) state_nxt = ST_REQ;
            ST_REQ: begin
                bus.pix_req = 1'b1;
                if (bus.pix_ack) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                bus.push  = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT:  if (bus.valid) state_nxt = ST_WB;
            ST_WB: begin
                bus.wb_valid = 1'b1;
                state_nxt    = (last_col && last_row) ? ST_DONE : ST_REQ;
            end
            ST_DONE: begin
                bus.done  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: all state here is updated with <= so every register sees pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x       <= '0;
            y       <= '0;
            rev     <= 1'b0;
            err_q   <= 1'b0;
            h_prev  <= '0;
            h_fwd_q <= '0;
            h_bwd_q <= '0;
            v_fwd_q <= '0;
            v_bwd_q <= '0;
            data_q  <= '0;
            wb_h_q  <= '0;
            wb_v_q  <= '0;
            wb_x_q  <= '0;
            wb_y_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: if (bus.start) begin
                    rev   <= bus.reverse;
                    x     <= bus.reverse ? LAST_COL : '0;
                    y     <= bus.reverse ? LAST_ROW : '0;
                    err_q <= 1'b0;
                end
                ST_REQ: if (bus.pix_ack) begin
                    h_fwd_q <= first_col ? '0 : h_prev;
                    v_fwd_q <= first_row ? '0 : lb_rdata;
                    h_bwd_q <= bus.pix_h_bwd;
                    v_bwd_q <= bus.pix_v_bwd;
                    data_q  <= bus.pix_data;
                end
                ST_WAIT: if (bus.valid) begin
                    wb_h_q <= bus.horizontal_out;
                    wb_v_q <= bus.vertical_out;
                    wb_x_q <= x;
                    wb_y_q <= y;
                end
                ST_WB: begin
                    h_prev <= wb_h_q;
                    if (!(last_col && last_row)) begin
                        if (last_col) begin
                            x <= rev ? LAST_COL : '0;
                            y <= rev ? (y - 1'b1) : (y + 1'b1);
                        end else begin
                            x <= rev ? (x - 1'b1) : (x + 1'b1);
                        end
                    end
                end
                default: ;
            endcase
            // A stray result is dropped; only the sticky flag records it.
            if (bus.valid && state != ST_WAIT) begin
                err_q <= 1'b1;
            end
        end
    end

    trws_line_buffer #(
        .DEPTH     (IMG_WIDTH),
        .ADDR_BITS (COL_BITS)
    ) u_line_buffer (
        .clk   (clk),
        .we    (state == ST_WB),
        .addr  (x),
        .wdata (wb_v_q),
        .rdata (lb_rdata)
    );

    assign bus.err                         = err_q;
    assign bus.pix_x                       = x;
    assign bus.pix_y                       = y;
    assign bus.horizontal_message_forward  = h_fwd_q;
    assign bus.horizontal_message_backward = h_bwd_q;
    assign bus.vertical_message_forward    = v_fwd_q;
    assign bus.vertical_message_backward   = v_bwd_q;
    assign bus.data                        = data_q;
    assign bus.wb_h_msg                    = wb_h_q;
    assign bus.wb_v_msg                    = wb_v_q;
    assign bus.wb_x                        = wb_x_q;
    assign bus.wb_y                        = wb_y_q;

endmodule

// File: tb/tb_trws_scan_sequencer.sv
// Directed bench for trws_scan_sequencer on a 2x2 image with an 8-cycle passer model.
module tb_trws_scan_sequencer;
    import trws_pkg::*;

    localparam int W = 2;
    localparam int H = 2;

    typedef struct {
        int        idx;
        msg_bus_t  hf;
        msg_bus_t  vf;
        msg_bus_t  hb;
        msg_bus_t  vb;
        data_bus_t d;
    } push_rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    int        ack_delay = 0;
    int        req_cnt = 0;
    int        out_ofs = 0;
    logic      inject = 1'b0;
    logic [7:0] vpipe;
    int        ipipe [8];

    int        wb_idx [$];
    int        wb_cyc [$];
    push_rec_t push_q [$];
    int        push_wide = 0;
    logic      push_prev = 1'b0;
    logic      done_seen = 1'b0;
    int        done_cyc = 0;
    int        start_cyc = 0;

    trws_scan_sequencer_if #(.COL_BITS(1), .ROW_BITS(1)) bus ();

    trws_scan_sequencer #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .COL_BITS   (1),
        .ROW_BITS   (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic msg_bus_t rep_msg(input int v);
        logic [MESSAGE_WIDTH-1:0] b;
        b = MESSAGE_WIDTH'(v);
        return {LABELS{b}};
    endfunction

    function automatic data_bus_t rep_data(input int v);
        logic [DATA_WIDTH-1:0] b;
        b = DATA_WIDTH'(v);
        return {LABELS{b}};
    endfunction

    function automatic int cur_idx();
        return int'(bus.pix_y) * W + int'(bus.pix_x);
    endfunction

    // Memory store and 8-cycle passer model.
    assign bus.pix_ack        = bus.pix_req && (req_cnt >= ack_delay);
    assign bus.pix_data       = rep_data(cur_idx() + 16);
    assign bus.pix_h_bwd      = rep_msg(cur_idx() + 32);
    assign bus.pix_v_bwd      = rep_msg(cur_idx() + 40);
    assign bus.valid          = vpipe[7] | inject;
    assign bus.horizontal_out = inject ? rep_msg(63) : rep_msg(ipipe[7] + out_ofs);
    assign bus.vertical_out   = inject ? rep_msg(63) : rep_msg(ipipe[7] + out_ofs);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.pix_req && !bus.pix_ack) req_cnt <= req_cnt + 1;
        else req_cnt <= 0;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            vpipe <= '0;
            for (int i = 0; i < 8; i++) ipipe[i] <= 0;
        end else begin
            vpipe <= {vpipe[6:0], bus.push};
            for (int i = 7; i > 0; i--) ipipe[i] <= ipipe[i-1];
            ipipe[0] <= cur_idx();
        end
    end

    always @(negedge clk) begin
        if (bus.wb_valid) begin
            wb_idx.push_back(int'(bus.wb_y) * W + int'(bus.wb_x));
            wb_cyc.push_back(cyc);
        end
        if (bus.push) begin
            push_rec_t r;
            r.idx = cur_idx();
            r.hf  = bus.horizontal_message_forward;
            r.vf  = bus.vertical_message_forward;
            r.hb  = bus.horizontal_message_backward;
            r.vb  = bus.vertical_message_backward;
            r.d   = bus.data;
            push_q.push_back(r);
            if (push_prev) push_wide++;
        end
        push_prev = bus.push;
        if (bus.done) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
        end
    end

    task automatic start_scan(input logic rev);
        wb_idx.delete();
        wb_cyc.delete();
        push_q.delete();
        push_wide = 0;
        done_seen = 1'b0;
        @(negedge clk);
        bus.reverse = rev;
        bus.start   = 1'b1;
        @(posedge clk);
        #1 start_cyc = cyc;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int pulse_at);
        for (int i = 0; i < 400 && !done_seen; i++) begin
            @(negedge clk);
            if (i == pulse_at) bus.start = 1'b1;
            if (i == pulse_at + 1) bus.start = 1'b0;
        end
        bus.start = 1'b0;
        checks++;
        if (!done_seen) begin
            failures++;
            $display("FAIL done_timeout: got no done, expected done within 400 cycles");
        end
    endtask

    task automatic check_order(input string name, input int e0, input int e1, input int e2, input int e3);
        int exp_q [4];
        exp_q = '{e0, e1, e2, e3};
        checks++;
        if (wb_idx.size() != 4) begin
            failures++;
            $display("FAIL %s_count: got %0d writebacks, expected 4", name, wb_idx.size());
        end
        for (int i = 0; i < 4 && i < wb_idx.size(); i++) begin
            checks++;
            if (wb_idx[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL %s_wb%0d: got pixel %0d, expected %0d", name, i, wb_idx[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.err, bus.pix_req, bus.push, bus.wb_valid} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b, expected 000000",
                     {bus.busy, bus.done, bus.err, bus.pix_req, bus.push, bus.wb_valid});
        end
        checks++;
        if ({bus.pix_x, bus.pix_y, bus.wb_x, bus.wb_y} !== 4'b0) begin
            failures++;
            $display("FAIL reset_coords: got %b, expected 0000", {bus.pix_x, bus.pix_y, bus.wb_x, bus.wb_y});
        end
        checks++;
        if ((bus.horizontal_message_forward | bus.vertical_message_backward | bus.wb_h_msg) !== '0
            || bus.data !== '0) begin
            failures++;
            $display("FAIL reset_buses: got nonzero message/data bus, expected 0");
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_forward();
        start_scan(1'b0);
        wait_done(-1);
        check_order("fwd", 0, 1, 2, 3);
        checks++;
        if (done_cyc - start_cyc !== 44) begin
            failures++;
            $display("FAIL fwd_done_latency: got %0d, expected 44", done_cyc - start_cyc);
        end
        checks++;
        if (wb_cyc.size() >= 2 && wb_cyc[1] - wb_cyc[0] !== 11) begin
            failures++;
            $display("FAIL fwd_period: got %0d, expected 11", wb_cyc[1] - wb_cyc[0]);
        end
        checks++;
        if (push_q.size() != 4 || push_q[3].hf !== rep_msg(2) || push_q[3].vf !== rep_msg(1)) begin
            failures++;
            $display("FAIL fwd_p11_msgs: got h=%h v=%h, expected h=%h v=%h",
                     push_q[3].hf, push_q[3].vf, rep_msg(2), rep_msg(1));
        end
    endtask

    task automatic test_boundary_zeros();
        out_ofs = 8;
        start_scan(1'b0);
        wait_done(-1);
        checks++;
        if (push_q[0].hf !== '0 || push_q[0].vf !== '0) begin
            failures++;
            $display("FAIL bnd_p00: got h=%h v=%h, expected 0", push_q[0].hf, push_q[0].vf);
        end
        checks++;
        if (push_q[2].idx !== 2 || push_q[2].hf !== '0 || push_q[2].vf !== rep_msg(8)) begin
            failures++;
            $display("FAIL bnd_p01: got idx=%0d h=%h v=%h, expected idx=2 h=0 v=%h",
                     push_q[2].idx, push_q[2].hf, push_q[2].vf, rep_msg(8));
        end
        checks++;
        if (push_q[1].d !== rep_data(17) || push_q[1].hb !== rep_msg(33) || push_q[1].vb !== rep_msg(41)) begin
            failures++;
            $display("FAIL bnd_passthru: got d=%h hb=%h vb=%h, expected d=%h hb=%h vb=%h",
                     push_q[1].d, push_q[1].hb, push_q[1].vb, rep_data(17), rep_msg(33), rep_msg(41));
        end
        checks++;
        if (bus.wb_h_msg !== rep_msg(11) || bus.wb_v_msg !== rep_msg(11)) begin
            failures++;
            $display("FAIL bnd_last_wb: got h=%h v=%h, expected %h", bus.wb_h_msg, bus.wb_v_msg, rep_msg(11));
        end
        out_ofs = 0;
    endtask

    task automatic test_reverse();
        start_scan(1'b1);
        wait_done(-1);
        check_order("rev", 3, 2, 1, 0);
        checks++;
        if (push_q[1].hf !== rep_msg(3) || push_q[1].vf !== '0) begin
            failures++;
            $display("FAIL rev_p01: got h=%h v=%h, expected h=%h v=0", push_q[1].hf, push_q[1].vf, rep_msg(3));
        end
        checks++;
        if (push_q[2].idx !== 1 || push_q[2].hf !== '0 || push_q[2].vf !== rep_msg(3)) begin
            failures++;
            $display("FAIL rev_p10: got idx=%0d h=%h v=%h, expected idx=1 h=0 v=%h",
                     push_q[2].idx, push_q[2].hf, push_q[2].vf, rep_msg(3));
        end
    endtask

    task automatic test_ack_delay();
        ack_delay = 5;
        start_scan(1'b0);
        wait_done(30);
        check_order("dly", 0, 1, 2, 3);
        checks++;
        if (wb_cyc.size() == 4 && (wb_cyc[1] - wb_cyc[0] !== 16 || wb_cyc[3] - wb_cyc[2] !== 16)) begin
            failures++;
            $display("FAIL dly_period: got %0d/%0d, expected 16/16", wb_cyc[1] - wb_cyc[0], wb_cyc[3] - wb_cyc[2]);
        end
        checks++;
        if (done_cyc - start_cyc !== 64) begin
            failures++;
            $display("FAIL dly_done_latency: got %0d, expected 64", done_cyc - start_cyc);
        end
        checks++;
        if (push_q.size() != 4 || push_wide !== 0) begin
            failures++;
            $display("FAIL dly_push_width: got %0d pushes, %0d wide, expected 4, 0", push_q.size(), push_wide);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL dly_mid_start: got busy=%b after done, expected 0", bus.busy);
        end
        ack_delay = 0;
    endtask

    task automatic test_spurious_valid();
        int n;
        start_scan(1'b0);
        n = 0;
        while (!(bus.pix_req && wb_idx.size() == 1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        checks++;
        if (bus.err !== 1'b1) begin
            failures++;
            $display("FAIL spur_err_set: got err=%b, expected 1", bus.err);
        end
        wait_done(-1);
        check_order("spur", 0, 1, 2, 3);
        checks++;
        if (bus.err !== 1'b1) begin
            failures++;
            $display("FAIL spur_err_sticky: got err=%b, expected 1", bus.err);
        end
        start_scan(1'b0);
        checks++;
        if (bus.err !== 1'b0) begin
            failures++;
            $display("FAIL spur_err_clear: got err=%b, expected 0", bus.err);
        end
        wait_done(-1);
    endtask

    task automatic test_rst_mid_scan();
        int n;
        start_scan(1'b0);
        n = 0;
        while (push_q.size() < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.pix_req, bus.push, bus.wb_valid} !== 5'b0) begin
            failures++;
            $display("FAIL rst_ctrl: got %b, expected 00000",
                     {bus.busy, bus.done, bus.pix_req, bus.push, bus.wb_valid});
        end
        checks++;
        if (bus.wb_h_msg !== '0 || bus.horizontal_message_forward !== '0 || bus.data !== '0
            || {bus.wb_x, bus.wb_y, bus.pix_x, bus.pix_y} !== 4'b0) begin
            failures++;
            $display("FAIL rst_buses: got nonzero bus after reset, expected 0");
        end
        checks++;
        if (wb_idx.size() !== 1) begin
            failures++;
            $display("FAIL rst_partial_wb: got %0d writebacks, expected 1", wb_idx.size());
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        start_scan(1'b0);
        wait_done(-1);
        check_order("rst", 0, 1, 2, 3);
        checks++;
        if (done_cyc - start_cyc !== 44) begin
            failures++;
            $display("FAIL rst_rescan_latency: got %0d, expected 44", done_cyc - start_cyc);
        end
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.reverse = 1'b0;
        test_reset();
        test_forward();
        test_boundary_zeros();
        test_reverse();
        test_ack_delay();
        test_spurious_valid();
        test_rst_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
